// File: rtl/ofdm_cp_remover_pkg.sv
// ofdm_cp_remover_pkg
// Shared definitions for the cyclic-prefix remover: settings-bus register
// offsets, power-on symbol geometry, the framing state type and a helper
// that maps a programmed FFT length onto the length actually used.
package ofdm_cp_remover_pkg;

   // Register offsets relative to the block's settings-bus base address
   localparam int unsigned SR_CP_LEN  = 0;
   localparam int unsigned SR_FFT_LEN = 1;

   // Power-on geometry matches 802.11a: 16-sample prefix, 64-point FFT
   localparam logic [15:0] DEFAULT_CP_LEN  = 16'd16;
   localparam logic [15:0] DEFAULT_FFT_LEN = 16'd64;

   // DROP discards prefix samples, PASS forwards the FFT body
   typedef enum logic {
      DROP = 1'b0,
      PASS = 1'b1
   } state_t;

   // A zero-length FFT body would never terminate a symbol, so it is
   // treated as a single-sample body instead.
   function automatic logic [15:0] effective_fft_len(input logic [15:0] len);
      return (len == 16'd0) ? 16'd1 : len;
   endfunction

endpackage

// File: rtl/ofdm_cp_remover_if.sv
// ofdm_cp_remover_if
// AXI-Stream style sample channel used on both sides of the CP remover.
//   tdata  : WIDTH-bit sample, {I, Q} halves for complex data
//   tlast  : end of burst (upstream side) / end of symbol (downstream side)
//   tvalid : producer has a sample
//   tready : consumer accepts the sample this cycle
// master : the producing side, slave : the consuming side.
interface ofdm_cp_remover_if #(
   parameter int WIDTH = 32
) ();

   logic [WIDTH-1:0] tdata;
   logic             tlast;
   logic             tvalid;
   logic             tready;

   modport master (
      output tdata,
      output tlast,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tlast,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/ofdm_cp_remover.sv
// ofdm_cp_remover
// Removes the cyclic prefix from each OFDM symbol of a time-aligned sample
// stream and emits exactly fft_len samples per symbol, with tlast on the
// final sample of each symbol. Prefix and FFT lengths are programmable over
// the settings bus; new values are latched only at symbol boundaries so a
// single symbol is never split across two geometries.
//
// Ports
//   clk        : single clock
//   reset      : synchronous, active-high; clears state, output and settings
//   clear      : synchronous; clears state and output, keeps settings
//   set_stb    : settings write strobe
//   set_addr   : settings address (BASE+0 cp_len, BASE+1 fft_len)
//   set_data   : settings data, lengths in bits [15:0]
//   upstream   : sample input from the synchronizer (tlast = end of burst)
//   downstream : sample output toward the FFT (tlast = end of symbol)
//   truncated  : one-cycle pulse after a burst ended mid-symbol
module ofdm_cp_remover
   import ofdm_cp_remover_pkg::*;
#(
   parameter int BASE  = 0,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   set_stb,
   input  logic [7:0]             set_addr,
   input  logic [31:0]            set_data,
   ofdm_cp_remover_if.slave       upstream,
   ofdm_cp_remover_if.master      downstream,
   output logic                   truncated
);

   localparam logic [7:0] ADDR_CP_LEN  = 8'(BASE + SR_CP_LEN);
   localparam logic [7:0] ADDR_FFT_LEN = 8'(BASE + SR_FFT_LEN);

   // Shadow (bus-written) and active (in-use) geometry
   logic [15:0] shadow_cp_len;
   logic [15:0] shadow_fft_len;
   logic [15:0] cp_len;
   logic [15:0] fft_len;

   // Framing state
   state_t      state;
   state_t      state_next;
   state_t      reload_state;
   logic [15:0] cnt;
   logic [15:0] cnt_next;

   // Per-cycle decisions from the framing logic
   logic        ready;
   logic        beat;
   logic        cp_done;
   logic        fft_done;
   logic        reload;
   logic        forward;
   logic        end_of_symbol;
   logic        truncate;

   // Single output register stage
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_valid;

   // Only the low halfword of settings data carries a length
   logic unused_set_data;
   assign unused_set_data = ^set_data[31:16];

   // Settings bus writes land in the shadow registers only; the framing
   // logic picks them up at the next boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_cp_len  <= DEFAULT_CP_LEN;
         shadow_fft_len <= DEFAULT_FFT_LEN;
      end else if (set_stb) begin
         if (set_addr == ADDR_CP_LEN) begin
            shadow_cp_len <= set_data[15:0];
         end
         if (set_addr == ADDR_FFT_LEN) begin
            shadow_fft_len <= set_data[15:0];
         end
      end
   end

   // A zero-length prefix means a new symbol starts directly in PASS,
   // decided from the value being loaded rather than the stale active one.
   assign reload_state = (shadow_cp_len == 16'd0) ? PASS : DROP;

   // Prefix samples are always accepted so the CP drains at full rate even
   // while the FFT side stalls; body samples need room in the output stage.
   // Nothing is accepted during reset or clear because that beat would be
   // thrown away by the restart.
   assign ready = !reset && !clear &&
                  ((state == DROP) || !out_valid || downstream.tready);
   assign upstream.tready = ready;
   assign beat            = upstream.tvalid && ready;

   // Exact compares against length-1; cnt only ever counts up to them
   assign cp_done  = (cnt == (cp_len - 16'd1));
   assign fft_done = (cnt == (fft_len - 16'd1));

   // Framing state register and active geometry. The active lengths are
   // refreshed from the shadow copies on every symbol boundary as well as
   // on clear, so a write that coincides with a reload waits for the next.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= DROP;
         cnt     <= '0;
         cp_len  <= DEFAULT_CP_LEN;
         fft_len <= DEFAULT_FFT_LEN;
      end else if (clear) begin
         state   <= reload_state;
         cnt     <= '0;
         cp_len  <= shadow_cp_len;
         fft_len <= effective_fft_len(shadow_fft_len);
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (reload) begin
            cp_len  <= shadow_cp_len;
            fft_len <= effective_fft_len(shadow_fft_len);
         end
      end
   end

   // Next-state logic. Any burst end or symbol end funnels through the
   // shared reload path, which restarts the count and picks DROP or PASS
   // from the geometry about to be loaded. A burst end before the symbol
   // is complete is flagged as a truncation; a burst that ends exactly on
   // the last body sample is a clean symbol end.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      reload        = 1'b0;
      forward       = 1'b0;
      end_of_symbol = 1'b0;
      truncate      = 1'b0;

      case (state)
         DROP: begin
            if (beat) begin
               if (upstream.tlast) begin
                  reload   = 1'b1;
                  truncate = 1'b1;
               end else if (cp_done) begin
                  state_next = PASS;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 16'd1;
               end
            end
         end
         PASS: begin
            if (beat) begin
               forward       = 1'b1;
               end_of_symbol = fft_done || upstream.tlast;
               if (end_of_symbol) begin
                  reload   = 1'b1;
                  truncate = !fft_done;
               end else begin
                  cnt_next = cnt + 16'd1;
               end
            end
         end
         default: begin
            state_next = DROP;
         end
      endcase

      if (reload) begin
         state_next = reload_state;
         cnt_next   = '0;
      end
   end

   // Output stage: loads on a forwarded beat, empties once the consumer
   // takes it, and otherwise holds data and tlast steady under backpressure.
   // Reset and clear abandon whatever partial symbol was in flight.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         truncated <= 1'b0;
      end else begin
         truncated <= truncate;
         if (forward) begin
            out_valid <= 1'b1;
            out_data  <= upstream.tdata;
            out_last  <= end_of_symbol;
         end else if (downstream.tready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign downstream.tdata  = out_data;
   assign downstream.tlast  = out_last;
   assign downstream.tvalid = out_valid;

endmodule
